// File: rtl/bus_slave_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bus_slave_port_if                                         |
// | Purpose  : Serial bit-per-cycle bus between an interconnect master   |
// |            port and one bus_slave_port instance.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface bus_slave_port_if;
   logic master_valid;
   logic master_ready;
   logic rx_address;
   logic rx_data;
   logic write_en;
   logic read_en;
   logic tx_data;
   logic slave_valid;
   logic slave_ready;

   modport master (
      output master_valid, master_ready, rx_address, rx_data, write_en, read_en,
      input  tx_data, slave_valid, slave_ready
   );

   modport slave (
      input  master_valid, master_ready, rx_address, rx_data, write_en, read_en,
      output tx_data, slave_valid, slave_ready
   );
endinterface
`default_nettype wire

// File: rtl/bus_slave_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bus_slave_port                                            |
// | Purpose  : Slave responder for the serial bus. Deserialises address  |
// |            and write data (LSB first), writes/reads a local word     |
// |            memory and serialises read data back with valid/ready.    |
// | Options  : SLAVE_READ_WAIT_EN - inserts READ_WAIT idle cycles before |
// |            read data is presented.                                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bus_slave_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 4096,
   parameter int READ_WAIT  = 4
) (
   input wire              clk,
   input wire              rst,
   bus_slave_port_if.slave bus
);

   localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W  = $clog2(MAX_W + 1);
   localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WDATA = 3'd2,
      S_WRITE = 3'd3,
      S_RDMEM = 3'd4,
`ifdef SLAVE_READ_WAIT_EN
      S_RWAIT = 3'd5,
`endif
      S_TX    = 3'd6
   } state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_is_write, w_is_write_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
   logic [DATA_WIDTH-1:0] r_rbuf, w_rbuf_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic                  r_tx_data, w_tx_data_nxt;
   logic                  r_slave_valid, w_slave_valid_nxt;
   logic                  r_slave_ready, w_slave_ready_nxt;

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic                  w_addr_in_range;
   logic [DATA_WIDTH-1:0] w_mem_rd;
   logic [DATA_WIDTH-1:0] w_rbuf_shift;

`ifdef SLAVE_READ_WAIT_EN
   localparam int WAIT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
   logic [WAIT_W-1:0] r_wait, w_wait_nxt;
`else
   // READ_WAIT only shapes the wait state, which is compiled out in this build.
   if (READ_WAIT < 0) begin : g_read_wait_unused
   end
`endif

   // Addresses beyond the memory are legal on the bus: writes drop, reads return zero.
   assign w_addr_in_range = int'(r_addr) < MEM_DEPTH;
   assign w_mem_rd        = w_addr_in_range ? r_mem[r_addr[MEM_AW-1:0]] : '0;
   assign w_rbuf_shift    = r_rbuf >> 1;

   assign bus.tx_data     = r_tx_data;
   assign bus.slave_valid = r_slave_valid;
   assign bus.slave_ready = r_slave_ready;

   // State and datapath registers; memory deliberately lives outside the reset domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_is_write    <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_rbuf        <= '0;
         r_cnt         <= '0;
         r_tx_data     <= 1'b0;
         r_slave_valid <= 1'b0;
         r_slave_ready <= 1'b1;
`ifdef SLAVE_READ_WAIT_EN
         r_wait        <= '0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_is_write    <= w_is_write_nxt;
         r_addr        <= w_addr_nxt;
         r_wdata       <= w_wdata_nxt;
         r_rbuf        <= w_rbuf_nxt;
         r_cnt         <= w_cnt_nxt;
         r_tx_data     <= w_tx_data_nxt;
         r_slave_valid <= w_slave_valid_nxt;
         r_slave_ready <= w_slave_ready_nxt;
`ifdef SLAVE_READ_WAIT_EN
         r_wait        <= w_wait_nxt;
`endif
      end
   end

   // Next-state and next-output decode. A field completes when the counter
   // reaches its width; the transition happens on the following cycle.
   always_comb begin
      w_state_nxt       = r_state;
      w_is_write_nxt    = r_is_write;
      w_addr_nxt        = r_addr;
      w_wdata_nxt       = r_wdata;
      w_rbuf_nxt        = r_rbuf;
      w_cnt_nxt         = r_cnt;
      w_tx_data_nxt     = r_tx_data;
      w_slave_valid_nxt = r_slave_valid;
`ifdef SLAVE_READ_WAIT_EN
      w_wait_nxt        = r_wait;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.master_valid && (bus.write_en ^ bus.read_en)) begin
               w_is_write_nxt = bus.write_en;
               w_addr_nxt     = {bus.rx_address, r_addr[ADDR_WIDTH-1:1]};
               w_cnt_nxt      = CNT_W'(1);
               w_state_nxt    = S_ADDR;
            end
         end
         S_ADDR: begin
            if (r_cnt == CNT_W'(ADDR_WIDTH)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = r_is_write ? S_WDATA : S_RDMEM;
            end else if (bus.master_valid) begin
               w_addr_nxt = {bus.rx_address, r_addr[ADDR_WIDTH-1:1]};
               w_cnt_nxt  = r_cnt + CNT_W'(1);
            end
         end
         S_WDATA: begin
            if (r_cnt == CNT_W'(DATA_WIDTH)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_WRITE;
            end else if (bus.master_valid) begin
               w_wdata_nxt = {bus.rx_data, r_wdata[DATA_WIDTH-1:1]};
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         S_WRITE: begin
            w_state_nxt = S_IDLE;
         end
         S_RDMEM: begin
            w_rbuf_nxt = w_mem_rd;
`ifdef SLAVE_READ_WAIT_EN
            w_wait_nxt  = '0;
            w_state_nxt = S_RWAIT;
`else
            w_tx_data_nxt     = w_mem_rd[0];
            w_slave_valid_nxt = 1'b1;
            w_state_nxt       = S_TX;
`endif
         end
`ifdef SLAVE_READ_WAIT_EN
         S_RWAIT: begin
            if (int'(r_wait) >= READ_WAIT - 1) begin
               w_tx_data_nxt     = r_rbuf[0];
               w_slave_valid_nxt = 1'b1;
               w_state_nxt       = S_TX;
            end else begin
               w_wait_nxt = r_wait + WAIT_W'(1);
            end
         end
`endif
         S_TX: begin
            if (bus.master_ready) begin
               if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                  w_cnt_nxt         = '0;
                  w_tx_data_nxt     = 1'b0;
                  w_slave_valid_nxt = 1'b0;
                  w_state_nxt       = S_IDLE;
               end else begin
                  w_rbuf_nxt    = w_rbuf_shift;
                  w_tx_data_nxt = w_rbuf_shift[0];
                  w_cnt_nxt     = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_cnt_nxt         = '0;
            w_slave_valid_nxt = 1'b0;
            w_state_nxt       = S_IDLE;
         end
      endcase
      w_slave_ready_nxt = (w_state_nxt == S_IDLE);
   end

   // Memory write port; out-of-range writes are silently dropped.
   always_ff @(posedge clk) begin
      if (r_state == S_WRITE && w_addr_in_range) begin
         r_mem[r_addr[MEM_AW-1:0]] <= r_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bus_slave_port                                         |
// | Purpose  : Self-checking bench for bus_slave_port. Expected read     |
// |            bits are queued from a reference memory model when a read |
// |            is issued and popped as the slave hands them over.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_bus_slave_port;

   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int DEPTH = 2048;
   localparam int RW    = 4;
`ifdef SLAVE_READ_WAIT_EN
   localparam int EXP_RD_LAT = 2 + RW;
`else
   localparam int EXP_RD_LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst;

   bus_slave_port_if bus ();

   bus_slave_port #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_DEPTH  (DEPTH),
      .READ_WAIT  (RW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic       sb_q [$];
   logic [7:0] model_mem [int];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Drives one serial field starting at the current falling edge; returns on
   // the falling edge after the last bit was sampled, with master_valid low.
   task automatic send_field(input logic [11:0] val, input int n, input bit on_addr, input int stall_at);
      bus.master_valid = 1'b1;
      if (on_addr) bus.rx_address = val[0]; else bus.rx_data = val[0];
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus.write_en = ~bus.write_en;
            bus.read_en  = ~bus.read_en;
         end
         if (i == stall_at) begin
            bus.master_valid = 1'b0;
            repeat (3) begin
               if (on_addr) bus.rx_address = ~val[i]; else bus.rx_data = ~val[i];
               @(negedge clk);
            end
            bus.master_valid = 1'b1;
         end
         if (on_addr) bus.rx_address = val[i]; else bus.rx_data = val[i];
      end
      @(negedge clk);
      bus.master_valid = 1'b0;
      bus.write_en     = 1'b0;
      bus.read_en      = 1'b0;
   endtask

   task automatic do_write(input logic [11:0] addr, input logic [7:0] data, input int stall_a, input int stall_d);
      bus.write_en = 1'b1;
      bus.read_en  = 1'b0;
      send_field(addr, AW, 1'b1, stall_a);
      @(negedge clk);
      send_field({4'h0, data}, DW, 1'b0, stall_d);
      @(negedge clk);
      check_eq("wr_ready_busy", bus.slave_ready, 1'b0);
      @(negedge clk);
      check_eq("wr_ready_back", bus.slave_ready, 1'b1);
      if (int'(addr) < DEPTH) model_mem[int'(addr)] = data;
   endtask

   task automatic do_read(input logic [11:0] addr, input bit toggle_ready);
      logic [7:0] exp_word;
      int         lat;
      int         acc;
      int         cyc;
      logic       hold_pending;
      logic       hold_bit;
      exp_word = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : 8'h00;
      for (int i = 0; i < DW; i++) sb_q.push_back(exp_word[i]);
      bus.write_en = 1'b0;
      bus.read_en  = 1'b1;
      send_field(addr, AW, 1'b1, -1);
      lat = 0;
      while (!bus.slave_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_eq("rd_latency", lat, EXP_RD_LAT);
      check_eq("rd_ready_busy", bus.slave_ready, 1'b0);
      acc = 0;
      cyc = 0;
      hold_pending = 1'b0;
      hold_bit = 1'b0;
      while (acc < DW && cyc < 100) begin
         bus.master_ready = toggle_ready ? (cyc % 2 == 0) : 1'b1;
         if (hold_pending) begin
            check_eq("rd_hold_bit", bus.tx_data, hold_bit);
            check_eq("rd_hold_valid", bus.slave_valid, 1'b1);
         end
         hold_pending = 1'b0;
         if (bus.slave_valid && bus.master_ready) begin
            if (sb_q.size() == 0) check_eq("rd_sb_underflow", 1, 0);
            else check_eq("rd_bit", bus.tx_data, sb_q.pop_front());
            acc++;
         end else if (bus.slave_valid) begin
            hold_pending = 1'b1;
            hold_bit     = bus.tx_data;
         end
         cyc++;
         @(negedge clk);
      end
      bus.master_ready = 1'b0;
      check_eq("rd_accept_count", acc, DW);
      check_eq("rd_valid_drop", bus.slave_valid, 1'b0);
      check_eq("rd_ready_back", bus.slave_ready, 1'b1);
      check_eq("rd_sb_empty", sb_q.size(), 0);
      sb_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst              = 1'b1;
      bus.master_valid = 1'b0;
      bus.master_ready = 1'b0;
      bus.rx_address   = 1'b0;
      bus.rx_data      = 1'b0;
      bus.write_en     = 1'b0;
      bus.read_en      = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", bus.slave_ready, 1'b1);
      check_eq("rst_valid", bus.slave_valid, 1'b0);
      check_eq("rst_tx_data", bus.tx_data, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Basic write then read back, steady ready.
      do_write(12'h005, 8'hA5, -1, -1);
      do_read(12'h005, 1'b0);

      // Read with master_ready toggling.
      do_write(12'h123, 8'h3B, -1, -1);
      do_read(12'h123, 1'b1);

      // master_valid stalls mid-address and mid-data.
      do_write(12'h0F0, 8'hC6, 5, 3);
      do_read(12'h0F0, 1'b0);

      // Both enables, then neither: no start.
      bus.master_valid = 1'b1;
      bus.write_en     = 1'b1;
      bus.read_en      = 1'b1;
      bus.rx_address   = 1'b1;
      bus.rx_data      = 1'b1;
      @(negedge clk);
      check_eq("both_en_ready", bus.slave_ready, 1'b1);
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      @(negedge clk);
      check_eq("no_en_ready", bus.slave_ready, 1'b1);
      bus.master_valid = 1'b0;
      @(negedge clk);
      check_eq("idle_ready", bus.slave_ready, 1'b1);
      do_read(12'h005, 1'b1);

      // Out-of-range write dropped; read returns zero.
      do_write(12'h900, 8'h3C, -1, -1);
      do_read(12'h900, 1'b0);

      // Reset mid-WDATA aborts the write.
      bus.write_en = 1'b1;
      bus.read_en  = 1'b0;
      send_field(12'h005, AW, 1'b1, -1);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.master_valid = 1'b1;
         bus.rx_data      = i[0];
         @(negedge clk);
      end
      check_eq("pre_rst_ready", bus.slave_ready, 1'b0);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_ready", bus.slave_ready, 1'b1);
      check_eq("mid_rst_valid", bus.slave_valid, 1'b0);
      @(negedge clk);
      rst              = 1'b0;
      bus.master_valid = 1'b0;
      @(negedge clk);
      do_read(12'h005, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
